// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the machine-mode timer interrupt controller:
// CSR addresses, implemented bit positions, trap cause and FSM encoding.
package timer_irq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MTIP_BIT = 7;

    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ENTER = 2'd2
    } trap_state_e;

    // Word-align an address; mtvec and mepc never hold the low two bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/irq_csr_file.sv
// Machine-mode interrupt CSR storage: software read/write with field masking,
// plus hardware update ports for trap entry, mret and the timer pending bit.
module irq_csr_file
    import timer_irq_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        mtip_set,
    input  logic        trap_enter,
    input  logic        mret_exec,
    input  logic [31:0] epc,
    output logic        mie_bit,
    output logic        mtie_bit,
    output logic        mtip_bit,
    output logic [31:0] mepc,
    output logic [31:0] mtvec
);

    logic        mie_r;
    logic        mpie_r;
    logic        mtie_r;
    logic        mtip_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;

    logic wr_mstatus_s;
    logic wr_mie_s;
    logic wr_mtvec_s;
    logic wr_mepc_s;
    logic wr_mcause_s;
    logic mtip_clr_s;
    logic [31:0] rdata_s;

    // Decode software write strobes per CSR.
    always_comb begin
        wr_mstatus_s = 1'b0;
        wr_mie_s     = 1'b0;
        wr_mtvec_s   = 1'b0;
        wr_mepc_s    = 1'b0;
        wr_mcause_s  = 1'b0;
        mtip_clr_s   = 1'b0;
        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: wr_mstatus_s = 1'b1;
                CSR_MIE:     wr_mie_s     = 1'b1;
                CSR_MTVEC:   wr_mtvec_s   = 1'b1;
                CSR_MEPC:    wr_mepc_s    = 1'b1;
                CSR_MCAUSE:  wr_mcause_s  = 1'b1;
                CSR_MIP:     mtip_clr_s   = ~csr_wdata[MTIP_BIT];
                default:     mtip_clr_s   = 1'b0;
            endcase
        end else begin
            mtip_clr_s = 1'b0;
        end
    end

    // CSR state; hardware trap/mret updates take priority over software writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mie_r    <= 1'b0;
            mpie_r   <= 1'b0;
            mtie_r   <= 1'b0;
            mtip_r   <= 1'b0;
            mtvec_r  <= align_word(MTVEC_RESET);
            mepc_r   <= 32'h0000_0000;
            mcause_r <= 32'h0000_0000;
        end else begin
            if (trap_enter) begin
                mpie_r <= mie_r;
                mie_r  <= 1'b0;
            end else if (mret_exec) begin
                mie_r  <= mpie_r;
                mpie_r <= 1'b1;
            end else if (wr_mstatus_s) begin
                mie_r  <= csr_wdata[MIE_BIT];
                mpie_r <= csr_wdata[MPIE_BIT];
            end

            if (wr_mie_s) begin
                mtie_r <= csr_wdata[MTIP_BIT];
            end

            if (wr_mtvec_s) begin
                mtvec_r <= align_word(csr_wdata);
            end

            if (trap_enter) begin
                mepc_r   <= align_word(epc);
                mcause_r <= MCAUSE_MTI;
            end else begin
                if (wr_mepc_s) begin
                    mepc_r <= align_word(csr_wdata);
                end
                if (wr_mcause_s) begin
                    mcause_r <= csr_wdata;
                end
            end

            // A fresh pulse beats any clear landing in the same cycle.
            if (mtip_set) begin
                mtip_r <= 1'b1;
            end else if (trap_enter || mtip_clr_s) begin
                mtip_r <= 1'b0;
            end
        end
    end

    // Combinational read mux; unimplemented bits and addresses read zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (csr_addr)
            CSR_MSTATUS: begin
                rdata_s[MIE_BIT]  = mie_r;
                rdata_s[MPIE_BIT] = mpie_r;
            end
            CSR_MIE:     rdata_s[MTIP_BIT] = mtie_r;
            CSR_MTVEC:   rdata_s = mtvec_r;
            CSR_MEPC:    rdata_s = mepc_r;
            CSR_MCAUSE:  rdata_s = mcause_r;
            CSR_MIP:     rdata_s[MTIP_BIT] = mtip_r;
            default:     rdata_s = 32'h0000_0000;
        endcase
    end

    assign csr_rdata = rdata_s;
    assign mie_bit   = mie_r;
    assign mtie_bit  = mtie_r;
    assign mtip_bit  = mtip_r;
    assign mepc      = mepc_r;
    assign mtvec     = mtvec_r;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt receiver and trap-entry controller: requests a trap from the
// pipeline, saves the interrupted PC and redirects fetch on trap entry or mret.
module timer_irq_ctrl
    import timer_irq_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        timer_interrupt,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic [31:0] retire_pc,
    output logic        trap_req,
    input  logic        trap_ack,
    input  logic        mret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    trap_state_e state_r;
    logic        trap_req_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;

    logic        mie_s;
    logic        mtie_s;
    logic        mtip_s;
    logic [31:0] mepc_s;
    logic [31:0] mtvec_s;
    logic        take_s;
    logic        trap_enter_s;
    logic        mret_exec_s;
    logic [31:0] mtvec_next_s;

    irq_csr_file #(
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk        (clk),
        .reset_n    (reset_n),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .mtip_set   (timer_interrupt),
        .trap_enter (trap_enter_s),
        .mret_exec  (mret_exec_s),
        .epc        (retire_pc),
        .mie_bit    (mie_s),
        .mtie_bit   (mtie_s),
        .mtip_bit   (mtip_s),
        .mepc       (mepc_s),
        .mtvec      (mtvec_s)
    );

    // Take condition, trap-vs-mret arbitration and the mtvec value seen in ENTER.
    always_comb begin
        take_s       = mtip_s & mtie_s & mie_s;
        trap_enter_s = (state_r == ST_REQ) & trap_ack;
        mret_exec_s  = mret & ~trap_enter_s;
        mtvec_next_s = mtvec_s;
        if (csr_we && (csr_addr == CSR_MTVEC)) begin
            mtvec_next_s = align_word(csr_wdata);
        end else begin
            mtvec_next_s = mtvec_s;
        end
    end

    // Trap FSM with registered request and redirect outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            trap_req_r       <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
        end else begin
            redirect_valid_r <= 1'b0;
            if (mret_exec_s) begin
                redirect_valid_r <= 1'b1;
                redirect_pc_r    <= mepc_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        state_r    <= ST_REQ;
                        trap_req_r <= 1'b1;
                    end else begin
                        trap_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (trap_ack) begin
                        state_r          <= ST_ENTER;
                        trap_req_r       <= 1'b0;
                        redirect_valid_r <= 1'b1;
                        redirect_pc_r    <= mtvec_next_s;
                    end else if (!take_s) begin
                        state_r    <= ST_IDLE;
                        trap_req_r <= 1'b0;
                    end else begin
                        trap_req_r <= 1'b1;
                    end
                end
                ST_ENTER: begin
                    state_r    <= ST_IDLE;
                    trap_req_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    trap_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign trap_req       = trap_req_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule
